// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: decodes Note-On / Note-Off / All-Notes-Off for one MIDI channel and allocates notes to stepper voices.
// Optional feature macro VOICE_STEAL_EN: when defined, a Note-On with every voice sounding steals the oldest voice.
module midi_voice_alloc #(
  parameter int unsigned NUM_VOICES    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [23:0]             MsgData,
  input  logic                    MsgDone,
  input  logic [3:0]              ChannelSel,
  output logic [7*NUM_VOICES-1:0] VoiceNote,
  output logic [NUM_VOICES-1:0]   VoiceActive,
  output logic                    Busy,
  output logic                    Dropped
);

  localparam int unsigned IW = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DECODE, S_SCAN, S_COMMIT} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ON, OP_OFF, OP_ALL} op_e;
  typedef logic [IW-1:0]                  idx_t;
  typedef logic [NUM_VOICES-1:0][IW-1:0]  rank_t;
  typedef logic [NUM_VOICES-1:0][6:0]     note_t;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  idx_t                    scan_q, scan_d;
  logic                    done_prev_q, done_prev_d;
  op_e                     op_q, op_d;
  logic [6:0]              key_q, key_d;
  logic                    match_vld_q, match_vld_d;
  idx_t                    match_idx_q, match_idx_d;
  logic                    free_vld_q, free_vld_d;
  idx_t                    free_idx_q, free_idx_d;
  logic                    old_vld_q, old_vld_d;
  idx_t                    old_idx_q, old_idx_d;
  note_t                   note_q, note_d;
  logic [NUM_VOICES-1:0]   act_q, act_d;
  rank_t                   rank_q, rank_d;
  logic                    busy_q, busy_d;
  logic                    dropped_q, dropped_d;

  logic       rise_c;
  logic [3:0] msg_kind;
  logic [3:0] msg_chan;
  logic [7:0] msg_note;
  logic [7:0] msg_vel;

  assign rise_c   = MsgDone & ~done_prev_q;
  assign msg_kind = MsgData[23:20];
  assign msg_chan = MsgData[19:16];
  assign msg_note = MsgData[15:8];
  assign msg_vel  = MsgData[7:0];

  assign VoiceNote   = note_q;
  assign VoiceActive = act_q;
  assign Busy        = busy_q;
  assign Dropped     = dropped_q;

  // Make voice v the newest; every voice younger than v ages by one so ranks stay a permutation.
  function automatic rank_t promote(input rank_t r, input idx_t v);
    rank_t o;
    o = r;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r[i] < r[v]) o[i] = r[i] + IW'(1);
    end
    o[v] = '0;
    return o;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      scan_q      <= '0;
      done_prev_q <= 1'b0;
      op_q        <= OP_NONE;
      key_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      note_q      <= '0;
      act_q       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= IW'(i);
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      done_prev_q <= done_prev_d;
      op_q        <= op_d;
      key_q       <= key_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      note_q      <= note_d;
      act_q       <= act_d;
      rank_q      <= rank_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    done_prev_d = MsgDone;
    op_d        = op_q;
    key_d       = key_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    note_d      = note_q;
    act_d       = act_q;
    rank_d      = rank_q;
    dropped_d   = 1'b0;

    // A new message while an operation is in flight is lost.
    if (rise_c && (state_q != S_IDLE)) dropped_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rise_c) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = S_DECODE;
        else                                 cnt_d   = cnt_q + CW'(1);
      end
      S_DECODE: begin
        state_d     = S_IDLE;
        op_d        = OP_NONE;
        key_d       = msg_note[6:0];
        scan_d      = '0;
        match_vld_d = 1'b0;
        free_vld_d  = 1'b0;
        old_vld_d   = 1'b0;
        if (msg_chan == ChannelSel) begin
          if ((msg_kind == 4'h9) && (msg_vel != 8'h00)) begin
            op_d    = OP_ON;
            state_d = S_SCAN;
          end else if ((msg_kind == 4'h8) || (msg_kind == 4'h9)) begin
            op_d    = OP_OFF;
            state_d = S_SCAN;
          end else if ((msg_kind == 4'hB) && (msg_note == 8'h7B)) begin
            op_d    = OP_ALL;
            state_d = S_COMMIT;
          end
        end
      end
      S_SCAN: begin
        // One voice per cycle; ascending order makes the first hit the lowest index.
        if (act_q[scan_q]) begin
          if (!match_vld_q && (note_q[scan_q] == key_q)) begin
            match_vld_d = 1'b1;
            match_idx_d = scan_q;
          end
          if (!old_vld_q || (rank_q[scan_q] > rank_q[old_idx_q])) begin
            old_vld_d = 1'b1;
            old_idx_d = scan_q;
          end
        end else if (!free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = scan_q;
        end
        if (scan_q == IW'(NUM_VOICES - 1)) state_d = S_COMMIT;
        else                               scan_d  = scan_q + IW'(1);
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        case (op_q)
          OP_ON: begin
            if (match_vld_q) begin
              rank_d = promote(rank_q, match_idx_q);
            end else if (free_vld_q) begin
              note_d[free_idx_q] = key_q;
              act_d[free_idx_q]  = 1'b1;
              rank_d             = promote(rank_q, free_idx_q);
            end else begin
`ifdef VOICE_STEAL_EN
              note_d[old_idx_q] = key_q;
              rank_d            = promote(rank_q, old_idx_q);
`else
              dropped_d = 1'b1;
`endif
            end
          end
          OP_OFF: begin
            if (match_vld_q) act_d[match_idx_q] = 1'b0;
          end
          OP_ALL:  act_d = '0;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: table of messages with hand-derived expected voice state, checked through a timed scoreboard.
module tb_midi_voice_alloc;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [23:0] MsgData;
  logic        MsgDone;
  logic [3:0]  ChannelSel;
  logic [27:0] VoiceNote;
  logic [3:0]  VoiceActive;
  logic        Busy;
  logic        Dropped;

  midi_voice_alloc #(.NUM_VOICES(4), .SETTLE_CYCLES(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .MsgData(MsgData), .MsgDone(MsgDone), .ChannelSel(ChannelSel),
    .VoiceNote(VoiceNote), .VoiceActive(VoiceActive), .Busy(Busy), .Dropped(Dropped)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;

  typedef struct {
    int          due;
    int          tag;
    logic [27:0] note;
    logic [3:0]  act;
    int          drops;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0]  ch;
    logic [23:0] msg;
    int          hold;
    int          lat;
    int          busy;
    logic [27:0] note;
    logic [3:0]  act;
    int          drops;
  } vec_t;
  vec_t tv[0:18];

  logic [27:0] cur_note;
  logic [3:0]  cur_act;
  int          cur_drops;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [27:0] vn(input logic [6:0] n3, input logic [6:0] n2,
                                     input logic [6:0] n1, input logic [6:0] n0);
    return {n3, n2, n1, n0};
  endfunction

  function automatic vec_t mk(input logic [3:0] ch, input logic [23:0] msg, input int hold,
                              input int lat, input int busy, input logic [27:0] note,
                              input logic [3:0] act, input int drops);
    vec_t v;
    v.ch = ch; v.msg = msg; v.hold = hold; v.lat = lat; v.busy = busy;
    v.note = note; v.act = act; v.drops = drops;
    return v;
  endfunction

  task automatic push(input int due, input int tag, input logic [27:0] note,
                      input logic [3:0] act, input int drops);
    exp_t e;
    e.due = due; e.tag = tag; e.note = note; e.act = act; e.drops = drops;
    sbq.push_back(e);
  endtask

  // Scoreboard: entries carry the cycle at which the DUT must present that state.
  always @(negedge Clk) begin
    if (Dropped === 1'b1) drop_cnt++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      if (mon_e.due < cyc) begin
        chk($sformatf("sb%0d_missed", mon_e.tag), 32'(cyc), 32'(mon_e.due));
      end else begin
        chk($sformatf("sb%0d_note", mon_e.tag),  32'(VoiceNote),   32'(mon_e.note));
        chk($sformatf("sb%0d_act", mon_e.tag),   32'(VoiceActive), 32'(mon_e.act));
        chk($sformatf("sb%0d_drops", mon_e.tag), 32'(drop_cnt),    32'(mon_e.drops));
      end
    end
  end

  // Drive one message; state must be unchanged at lat-1 and updated at lat.
  task automatic send(input int tag, input logic [3:0] ch, input logic [23:0] msg, input int hold,
                      input int lat, input logic [27:0] enote, input logic [3:0] eact,
                      input int edrops, output int busy_n);
    int c0;
    @(negedge Clk);
    ChannelSel = ch;
    MsgData    = msg;
    MsgDone    = 1'b1;
    c0         = cyc;
    push(c0 + lat - 1, 2 * tag,     cur_note, cur_act, cur_drops);
    push(c0 + lat,     2 * tag + 1, enote,    eact,    edrops);
    cur_note  = enote;
    cur_act   = eact;
    cur_drops = edrops;
    busy_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (k == hold) MsgDone = 1'b0;
      if (Busy === 1'b1) busy_n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dsteal;
    int bn;
    int c0;
    logic [27:0] n9;
`ifdef VOICE_STEAL_EN
    dsteal = 0;
    n9     = vn(7'h41, 7'h40, 7'h3E, 7'h48);
`else
    dsteal = 1;
    n9     = vn(7'h41, 7'h40, 7'h3E, 7'h3C);
`endif
    tv[0]  = mk(4'h0, 24'h903C64, 1, 9, 8, vn(7'h00, 7'h00, 7'h00, 7'h3C), 4'b0001, 0);
    tv[1]  = mk(4'h0, 24'h904064, 1, 9, 8, vn(7'h00, 7'h00, 7'h40, 7'h3C), 4'b0011, 0);
    tv[2]  = mk(4'h0, 24'h803C00, 1, 9, 8, vn(7'h00, 7'h00, 7'h40, 7'h3C), 4'b0010, 0);
    tv[3]  = mk(4'h0, 24'h904300, 1, 9, 8, vn(7'h00, 7'h00, 7'h40, 7'h3C), 4'b0010, 0);
    tv[4]  = mk(4'h0, 24'h904000, 1, 9, 8, vn(7'h00, 7'h00, 7'h40, 7'h3C), 4'b0000, 0);
    tv[5]  = mk(4'h0, 24'h903C64, 1, 9, 8, vn(7'h00, 7'h00, 7'h40, 7'h3C), 4'b0001, 0);
    tv[6]  = mk(4'h0, 24'h903E64, 1, 9, 8, vn(7'h00, 7'h00, 7'h3E, 7'h3C), 4'b0011, 0);
    tv[7]  = mk(4'h0, 24'h904064, 1, 9, 8, vn(7'h00, 7'h40, 7'h3E, 7'h3C), 4'b0111, 0);
    tv[8]  = mk(4'h0, 24'h904164, 1, 9, 8, vn(7'h41, 7'h40, 7'h3E, 7'h3C), 4'b1111, 0);
    tv[9]  = mk(4'h0, 24'h904864, 1, 9, 8, n9, 4'b1111, dsteal);
    tv[10] = mk(4'h0, 24'h904064, 1, 9, 8, n9, 4'b1111, dsteal);
    tv[11] = mk(4'h0, 24'hB07B00, 1, 5, 4, n9, 4'b0000, dsteal);
    tv[12] = mk(4'h2, 24'h913C64, 1, 9, 3, n9, 4'b0000, dsteal);
    tv[13] = mk(4'h2, 24'h923C64, 10, 9, 8, vn(7'h41, 7'h40, 7'h3E, 7'h3C), 4'b0001, dsteal);
    tv[14] = mk(4'h2, 24'h923C64, 1, 9, 8, vn(7'h41, 7'h40, 7'h3E, 7'h3C), 4'b0001, dsteal);
    tv[15] = mk(4'h2, 24'h924501, 1, 9, 8, vn(7'h41, 7'h40, 7'h45, 7'h3C), 4'b0011, dsteal);
    tv[16] = mk(4'h2, 24'hB27C00, 1, 9, 3, vn(7'h41, 7'h40, 7'h45, 7'h3C), 4'b0011, dsteal);
    tv[17] = mk(4'h2, 24'hA23C64, 1, 9, 3, vn(7'h41, 7'h40, 7'h45, 7'h3C), 4'b0011, dsteal);
    tv[18] = mk(4'h2, 24'hB27B00, 1, 5, 4, vn(7'h41, 7'h40, 7'h45, 7'h3C), 4'b0000, dsteal);

    Rst_n = 1'b0; MsgData = '0; MsgDone = 1'b0; ChannelSel = 4'h0;
    repeat (3) @(negedge Clk);
    chk("rst_note",    32'(VoiceNote),   32'h0);
    chk("rst_act",     32'(VoiceActive), 32'h0);
    chk("rst_busy",    32'(Busy),        32'h0);
    chk("rst_dropped", 32'(Dropped),     32'h0);
    Rst_n = 1'b1;
    cur_note = '0; cur_act = '0; cur_drops = 0;

    for (int i = 0; i <= 18; i++) begin
      send(i, tv[i].ch, tv[i].msg, tv[i].hold, tv[i].lat, tv[i].note, tv[i].act, tv[i].drops, bn);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'(tv[i].busy));
    end

    // Overrun: second rise during DECODE is dropped, first message completes.
    @(negedge Clk);
    MsgData = 24'h924764; MsgDone = 1'b1; c0 = cyc;
    push(c0 + 8, 200, cur_note, cur_act, cur_drops + 1);
    push(c0 + 9, 201, vn(7'h41, 7'h40, 7'h45, 7'h47), 4'b0001, cur_drops + 1);
    cur_note = vn(7'h41, 7'h40, 7'h45, 7'h47); cur_act = 4'b0001; cur_drops = cur_drops + 1;
    @(negedge Clk); MsgDone = 1'b0;
    @(negedge Clk);
    @(negedge Clk); MsgDone = 1'b1;
    @(negedge Clk);
    chk("ovr_dropped_pulse", 32'(Dropped), 32'h1);
    MsgDone = 1'b0;
    @(negedge Clk);
    chk("ovr_dropped_end", 32'(Dropped), 32'h0);
    repeat (5) @(negedge Clk);

    // Reset while scanning aborts the Note-On.
    @(negedge Clk);
    MsgData = 24'h924864; MsgDone = 1'b1;
    @(negedge Clk); MsgDone = 1'b0;
    repeat (4) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("midrst_note", 32'(VoiceNote),   32'h0);
    chk("midrst_act",  32'(VoiceActive), 32'h0);
    chk("midrst_busy", 32'(Busy),        32'h0);
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
    chk("midrst_act_after",  32'(VoiceActive), 32'h0);
    chk("midrst_busy_after", 32'(Busy),        32'h0);
    cur_note = '0; cur_act = '0;

    send(120, 4'h2, 24'h923C64, 1, 9, vn(7'h00, 7'h00, 7'h00, 7'h3C), 4'b0001, cur_drops, bn);
    chk("recover_busy_cycles", 32'(bn), 32'd8);
    send(121, 4'h2, 24'h923C64, 1, 9, vn(7'h00, 7'h00, 7'h00, 7'h3C), 4'b0001, cur_drops, bn);

    repeat (3) @(negedge Clk);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
